// File: rtl/serial_cfg_loader_pkg.sv
// Shared types and helpers for the serial configuration loader.
// The channel state encoding is fixed so that state dumps are comparable across builds.
package serial_cfg_loader_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } chan_state_e;

  // Ceiling log2, used to size the per-channel bit counter.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_cfg_if.sv
// Control and status bundle of the serial configuration loader.
// The master side drives the serial lines and strobes; the slave side is the loader.
interface serial_cfg_if #(
  parameter int unsigned NCH = 3,
  parameter int unsigned W   = 8
);

  logic             en;
  logic [NCH-1:0]   sdi;
  logic             rearm;
  logic             commit;
  logic [NCH*W-1:0] cfg_q;
  logic [NCH-1:0]   ch_done;
  logic             all_done;
  logic             upd;
  logic             cfg_valid;

  modport master (
    output en, sdi, rearm, commit,
    input  cfg_q, ch_done, all_done, upd, cfg_valid
  );

  modport slave (
    input  en, sdi, rearm, commit,
    output cfg_q, ch_done, all_done, upd, cfg_valid
  );

endinterface

// File: rtl/serial_cfg_chan.sv
// One serial channel: waits for a start bit, shifts in W bits MSB-first, then holds.
// The shadow word is never cleared so an aborted frame leaves stale bits that a full frame overwrites.
module serial_cfg_chan
  import serial_cfg_loader_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         sdi_i,
  input  logic         rearm_i,
  output logic         done_o,
  output logic [W-1:0] shadow_o
);

  localparam int unsigned CntW = clog2(W);
  localparam logic [CntW-1:0] LastCnt = CntW'(W - 1);

  chan_state_e   state_q;
  logic [CntW-1:0] cnt_q;
  logic [W-1:0]  shadow_q;
  logic          done_q;

  // Rearm outranks the enable and any start bit seen on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      shadow_q <= '0;
      done_q   <= 1'b0;
    end else if (rearm_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else if (en_i) begin
      case (state_q)
        StIdle: begin
          if (sdi_i) begin
            state_q <= StShift;
            cnt_q   <= '0;
          end
        end
        StShift: begin
          shadow_q <= {shadow_q[W-2:0], sdi_i};
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StDone;
        end
        default: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign done_o   = done_q;
  assign shadow_o = shadow_q;

endmodule

// File: rtl/serial_cfg_loader.sv
// NCH independent serial loaders with a shadow/active stage; the active words change
// only on a commit, which copies every channel's shadow in the same edge.
module serial_cfg_loader
  import serial_cfg_loader_pkg::*;
#(
  parameter int unsigned NCH         = 3,
  parameter int unsigned W           = 8,
  parameter int unsigned AUTO_COMMIT = 1
) (
  input logic        clk,
  input logic        rst_n,
  serial_cfg_if.slave bus
);

  logic [NCH-1:0][W-1:0] shadow;
  logic [NCH-1:0]        done;
  logic                  all_done;
  logic                  fire;

  logic [NCH*W-1:0] cfg_q_q, cfg_q_d;
  logic             committed_q, committed_d;
  logic             upd_q, upd_d;
  logic             valid_q, valid_d;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    serial_cfg_chan #(
      .W(W)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_i     (bus.en),
      .sdi_i    (bus.sdi[i]),
      .rearm_i  (bus.rearm),
      .done_o   (done[i]),
      .shadow_o (shadow[i])
    );
  end

  assign all_done = &done;

  always_comb begin
    if (AUTO_COMMIT != 0) begin
      fire = all_done & ~committed_q;
    end else begin
      fire = bus.commit & all_done;
    end
  end

  // A commit in the same cycle as rearm still lands; rearm then clears the committed flag.
  always_comb begin
    cfg_q_d     = cfg_q_q;
    committed_d = committed_q;
    valid_d     = valid_q;
    upd_d       = fire;
    if (fire) begin
      cfg_q_d     = shadow;
      committed_d = 1'b1;
      valid_d     = 1'b1;
    end
    if (bus.rearm) begin
      committed_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q_q     <= '0;
      committed_q <= 1'b0;
      upd_q       <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      cfg_q_q     <= cfg_q_d;
      committed_q <= committed_d;
      upd_q       <= upd_d;
      valid_q     <= valid_d;
    end
  end

  assign bus.cfg_q     = cfg_q_q;
  assign bus.ch_done   = done;
  assign bus.all_done  = all_done;
  assign bus.upd       = upd_q;
  assign bus.cfg_valid = valid_q;

endmodule

// File: tb/tb_serial_cfg_loader.sv
// Drives an auto-commit and a manual-commit loader with identical stimulus and checks both
// every cycle against a frame-level model of the channels and the commit stage.
module tb_serial_cfg_loader;

  localparam int NCH  = 3;
  localparam int W    = 8;
  localparam int SBUF = 512;

  logic clk;
  logic rst_n;

  serial_cfg_if #(.NCH(NCH), .W(W)) if_a ();
  serial_cfg_if #(.NCH(NCH), .W(W)) if_m ();

  serial_cfg_loader #(.NCH(NCH), .W(W), .AUTO_COMMIT(1)) u_dut_auto (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a)
  );

  serial_cfg_loader #(.NCH(NCH), .W(W), .AUTO_COMMIT(0)) u_dut_man (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: got[c] = -1 when idle, else number of data bits received (W = complete frame).
  int                    got [NCH];
  logic [NCH-1:0][W-1:0] sh;
  logic [NCH-1:0][W-1:0] cfg_a, cfg_m;
  bit                    comm_a, upd_a, val_a, upd_m, val_m;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) got[c] = -1;
    sh = '0; cfg_a = '0; cfg_m = '0;
    comm_a = 0; upd_a = 0; val_a = 0; upd_m = 0; val_m = 0;
  endtask

  function automatic bit model_all_done();
    for (int c = 0; c < NCH; c++) if (got[c] != W) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [NCH-1:0] model_done_vec();
    logic [NCH-1:0] v;
    for (int c = 0; c < NCH; c++) v[c] = (got[c] == W);
    return v;
  endfunction

  task automatic model_edge(input bit en, input logic [NCH-1:0] sdi, input bit rearm,
                            input bit commit);
    bit alld;
    alld  = model_all_done();
    upd_a = alld && !comm_a;
    if (upd_a) begin cfg_a = sh; comm_a = 1; val_a = 1; end
    upd_m = commit && alld;
    if (upd_m) begin cfg_m = sh; val_m = 1; end
    if (rearm) begin
      comm_a = 0;
      for (int c = 0; c < NCH; c++) got[c] = -1;
    end else if (en) begin
      for (int c = 0; c < NCH; c++) begin
        if (got[c] < 0) begin
          if (sdi[c]) got[c] = 0;
        end else if (got[c] < W) begin
          sh[c] = W'(int'(sh[c]) * 2 + int'(sdi[c]));
          got[c]++;
        end
      end
    end
  endtask

  task automatic check_outputs();
    check("a.cfg_q",     64'(if_a.cfg_q),     64'(cfg_a));
    check("a.ch_done",   64'(if_a.ch_done),   64'(model_done_vec()));
    check("a.all_done",  64'(if_a.all_done),  64'(model_all_done()));
    check("a.upd",       64'(if_a.upd),       64'(upd_a));
    check("a.cfg_valid", 64'(if_a.cfg_valid), 64'(val_a));
    check("m.cfg_q",     64'(if_m.cfg_q),     64'(cfg_m));
    check("m.ch_done",   64'(if_m.ch_done),   64'(model_done_vec()));
    check("m.upd",       64'(if_m.upd),       64'(upd_m));
    check("m.cfg_valid", 64'(if_m.cfg_valid), 64'(val_m));
  endtask

  // Per-channel serial bit streams; idle line is low once a stream runs dry.
  bit sbuf [NCH][SBUF];
  int sw [NCH];
  int sr [NCH];
  bit en_v, rearm_v, commit_v;

  task automatic clear_streams();
    for (int c = 0; c < NCH; c++) begin sw[c] = 0; sr[c] = 0; end
  endtask

  function automatic int pending();
    int p;
    p = 0;
    for (int c = 0; c < NCH; c++) p += sw[c] - sr[c];
    return p;
  endfunction

  task automatic push_frame(input int c, input int delay, input logic [W-1:0] v);
    for (int i = 0; i < delay; i++) begin sbuf[c][sw[c]] = 1'b0; sw[c]++; end
    sbuf[c][sw[c]] = 1'b1; sw[c]++;
    for (int i = W - 1; i >= 0; i--) begin sbuf[c][sw[c]] = v[i]; sw[c]++; end
  endtask

  task automatic tick();
    logic [NCH-1:0] sdi_v;
    for (int c = 0; c < NCH; c++) sdi_v[c] = (sr[c] < sw[c]) ? sbuf[c][sr[c]] : 1'b0;
    if_a.en = en_v; if_a.sdi = sdi_v; if_a.rearm = rearm_v; if_a.commit = commit_v;
    if_m.en = en_v; if_m.sdi = sdi_v; if_m.rearm = rearm_v; if_m.commit = commit_v;
    @(posedge clk);
    model_edge(en_v, sdi_v, rearm_v, commit_v);
    if (en_v) for (int c = 0; c < NCH; c++) if (sr[c] < sw[c]) sr[c]++;
    #1;
    check_outputs();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while (pending() != 0 && n < max_cycles) begin tick(); n++; end
    check("drain_bound", 64'(pending()), 64'(0));
  endtask

  task automatic do_rearm();
    rearm_v = 1; tick(); rearm_v = 0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    en_v = 1; rearm_v = 0; commit_v = 0;
    clear_streams();
    model_reset();
    if_a.en = 0; if_a.sdi = '0; if_a.rearm = 0; if_a.commit = 0;
    if_m.en = 0; if_m.sdi = '0; if_m.rearm = 0; if_m.commit = 0;
    rst_n = 1'b0;
    #12 rst_n = 1'b1;
    check_outputs();

    // Aligned frames, auto commit one edge after all channels complete.
    push_frame(0, 0, 8'hA5); push_frame(1, 0, 8'h3C); push_frame(2, 0, 8'hF0);
    ticks(1 + W);
    check("a.done_after_E0+W", 64'(if_a.ch_done), 64'(3'b111));
    check("a.no_upd_before",   64'(if_a.upd),     64'(0));
    tick();
    check("a.cfg_aligned", 64'(if_a.cfg_q),     64'(24'hF03CA5));
    check("a.upd_pulse",   64'(if_a.upd),       64'(1));
    check("a.valid_set",   64'(if_a.cfg_valid), 64'(1));
    tick();
    check("a.upd_one_cycle", 64'(if_a.upd), 64'(0));
    // Manual: two strobes, two pulses, same data.
    commit_v = 1; tick();
    check("m.cfg_commit1", 64'(if_m.cfg_q), 64'(24'hF03CA5));
    check("m.upd_commit1", 64'(if_m.upd),   64'(1));
    tick();
    check("m.upd_commit2", 64'(if_m.upd),   64'(1));
    commit_v = 0; tick();

    // Reload with skew and an enable gap; manual strobe held from the start.
    do_rearm();
    clear_streams();
    push_frame(0, 0, 8'h5A); push_frame(1, 0, 8'h00); push_frame(2, 5, 8'hFF);
    commit_v = 1;
    ticks(1);
    check("m.early_commit_ignored", 64'(if_m.upd), 64'(0));
    ticks(3);
    en_v = 0; ticks(3); en_v = 1;
    check("a.old_cfg_held", 64'(if_a.cfg_q), 64'(24'hF03CA5));
    drain(200);
    tick();
    check("a.cfg_reload", 64'(if_a.cfg_q), 64'(24'hFF005A));
    check("m.cfg_reload", 64'(if_m.cfg_q), 64'(24'hFF005A));
    commit_v = 0; ticks(2);

    // Abort channel 0 mid-frame, then a full frame; same-cycle rearm with the commit.
    do_rearm();
    clear_streams();
    push_frame(0, 0, 8'hEE); push_frame(1, 0, 8'h22); push_frame(2, 0, 8'h33);
    ticks(4);
    rearm_v = 1; tick(); rearm_v = 0;
    clear_streams();
    push_frame(0, 0, 8'h11); push_frame(1, 0, 8'h22); push_frame(2, 0, 8'h33);
    drain(200);
    rearm_v = 1; commit_v = 1; tick(); rearm_v = 0; commit_v = 0;
    check("a.cfg_after_abort", 64'(if_a.cfg_q),   64'(24'h332211));
    check("a.upd_with_rearm",  64'(if_a.upd),     64'(1));
    check("m.upd_with_rearm",  64'(if_m.upd),     64'(1));
    check("a.idle_after_rearm", 64'(if_a.ch_done), 64'(0));
    ticks(2);

    // Randomised frames, skews, enable gaps, strobes and stray rearms.
    for (int it = 0; it < 40; it++) begin
      do_rearm();
      clear_streams();
      for (int c = 0; c < NCH; c++) push_frame(c, $urandom_range(0, 6), W'($urandom));
      while (pending() != 0) begin
        en_v     = ($urandom_range(0, 3) != 0);
        commit_v = ($urandom_range(0, 3) == 0);
        rearm_v  = ($urandom_range(0, 49) == 0);
        tick();
      end
      en_v = 1; rearm_v = 0;
      commit_v = 0; tick();
      commit_v = 1; tick();
      commit_v = 0; tick();
    end

    // Asynchronous reset asserted mid-cycle.
    #3 rst_n = 1'b0;
    #1;
    check("rst.a.cfg_q",   64'(if_a.cfg_q),     64'(0));
    check("rst.a.ch_done", 64'(if_a.ch_done),   64'(0));
    check("rst.a.upd",     64'(if_a.upd),       64'(0));
    check("rst.a.valid",   64'(if_a.cfg_valid), 64'(0));
    check("rst.m.valid",   64'(if_m.cfg_valid), 64'(0));
    model_reset();
    clear_streams();
    @(negedge clk);
    rst_n = 1'b1;
    ticks(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_cfg_loader.md
Name: serial_cfg_loader

Overview:
- Parametrised successor to the per-field serial shift-loaders in the DAC control top. Loads NCH independent configuration words of W bits, one serial input per channel.
- Each channel frames its data with a start bit and stops itself after W bits.
- Shadow/active double buffering: the DAC-facing outputs change only on a coherent commit, never mid-frame.
- Adds re-arm without reset, plus auto or manual commit.

Parameters:
- NCH, 3, number of serial channels (vref, data, conver in the current top).
- W, 8, bits per channel word; must be >= 2.
- AUTO_COMMIT, 1, 1 = commit automatically when all channels are done; 0 = commit only on the commit strobe.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  sample enable; when 0, no channel FSM advances and no bit is sampled.
- sdi  in  NCH  serial data, bit i for channel i; MSB-first after the start bit.
- rearm  in  1  pulse: return all channels to IDLE to accept new frames.
- commit  in  1  manual commit strobe; used only when AUTO_COMMIT=0.
- cfg_q  out  NCH*W  active words; channel i occupies bits [i*W +: W].
- ch_done  out  NCH  channel i holds a complete shadow word.
- all_done  out  1  AND of ch_done.
- upd  out  1  one-cycle pulse: cfg_q updated at the preceding edge.
- cfg_valid  out  1  sticky; set by the first commit after reset.

Behaviour:
- Reset (async, rst_n=0): all channel FSMs to IDLE, shadow regs and cfg_q = 0, ch_done = 0, upd = 0, cfg_valid = 0, committed flag = 0. Reset mid-frame discards the partial frame.
- Channel FSM states: IDLE, SHIFT, DONE. Every transition is qualified by en=1.
- IDLE: sdi[i]=1 -> SHIFT, bit counter = 0. sdi[i]=0 -> stay; idle-low line.
- SHIFT: each enabled cycle, shadow <= {shadow[W-2:0], sdi[i]} and counter++. When counter == W-1 at the sampling edge -> DONE. The counter is ceil(log2 W) bits.
- DONE: ch_done[i]=1. Further sdi is ignored. Shadow holds until the next frame starts.
- Shadow is not cleared on IDLE->SHIFT; it shifts in place.
- rearm=1: every channel goes to IDLE from any state, ch_done clears, committed flag clears. cfg_q is untouched.
- rearm while a channel is in SHIFT aborts that frame. The partial shadow is never committed unless the channel later completes a full frame.
- Commit condition:
  - AUTO_COMMIT=1: all_done=1 and committed=0.
  - AUTO_COMMIT=0: commit=1 and all_done=1. commit with all_done=0 is ignored; no state change.
- On a commit edge: cfg_q <= concatenated shadows, committed <= 1, upd <= 1 for the next cycle only, cfg_valid <= 1.
- AUTO_COMMIT=0: repeated commit strobes while all_done=1 recommit the same data, each producing an upd pulse.
- Latency (en=1 throughout): start bit sampled at edge E0; last data bit at E0+W. ch_done is high after E0+W. The auto commit edge is the first edge at which all_done is already high, which is E0+W+1 for the slowest channel. cfg_q is valid and upd high after that edge.
- Same-cycle rearm and commit (or auto condition): the commit happens using the current shadows, then channels go to IDLE and committed clears. upd is still pulsed.
- The rearm in the same cycle as a start bit takes priority: that start bit is lost and the channel stays in IDLE.
- en=0 freezes the FSMs and counters. rearm and commit remain effective.
- Channels run independently. Frames may start at different cycles; only the commit aligns them.

Decomposition:
- Shared package: channel state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and a counter-width function clog2.
- One natural sub-module: serial_cfg_chan (one FSM, counter and shadow register), generated NCH times. The top holds the commit logic, committed flag and cfg_q.

Test Plan:
- Reset check: rst_n=0 asserted asynchronously mid-cycle -> cfg_q=0, ch_done=0, upd=0, cfg_valid=0 immediately.
- Auto load, NCH=3, W=8: frames 1+0xA5, 1+0x3C, 1+0xF0 start on the same edge -> all_done after edge 9; cfg_q={0xF0,0x3C,0xA5} after edge 10; upd high exactly one cycle; cfg_valid=1.
- Skewed frames: channel 2 starts 5 cycles late -> cfg_q unchanged until channel 2 is done; single upd pulse. en toggled 0 for 3 cycles mid-frame -> same result, shifted by 3 cycles.
- Abort: rearm at the 4th data bit of channel 0, then full frame 0x11 -> committed value 0x11; the earlier partial value never appears on cfg_q.
- Manual mode (AUTO_COMMIT=0):
  - commit before all_done -> ignored (no upd).
  - commit after all_done -> cfg_q updates, upd pulses.
  - second commit -> second upd, same data.
- Reload: after the first commit, rearm and load 0x5A/0x00/0xFF -> cfg_q holds the old values until the new commit, then switches atomically. Same-cycle rearm+commit -> commit occurs and channels return to IDLE.
